// File: rtl/fp_cmp_result80_if.sv
// Stream interface between the FP compare unit, this result stage and writeback.
// Carries the upstream compare payload with its valid/ready pair and the
// downstream result bus with its own valid/ready pair.
interface fp_cmp_result80_if #(
   parameter int unsigned TAGW = 6,
   parameter int unsigned RESW = 64
);
   logic            in_valid;
   logic            in_ready;
   logic [15:0]     in_cmp;
   logic            in_snan;
   logic            in_inf;
   logic [3:0]      in_op;
   logic            in_sig;
   logic [TAGW-1:0] in_tag;

   logic            out_valid;
   logic            out_ready;
   logic [RESW-1:0] out_res;
   logic [TAGW-1:0] out_tag;
   logic            out_nv;
   logic            out_illegal;

   // Environment side: drives compare payload, consumes results.
   modport master (
      output in_valid, in_cmp, in_snan, in_inf, in_op, in_sig, in_tag, out_ready,
      input  in_ready, out_valid, out_res, out_tag, out_nv, out_illegal
   );

   // Result stage side.
   modport slave (
      input  in_valid, in_cmp, in_snan, in_inf, in_op, in_sig, in_tag, out_ready,
      output in_ready, out_valid, out_res, out_tag, out_nv, out_illegal
   );
endinterface

// File: rtl/fp_cmp_result80.sv
// Result stage behind the 80-bit FP compare unit.
// Selects the requested predicate, computes the IEEE invalid exception
// (quiet vs signaling compare), keeps sticky nv/inf flags and hands results
// to writeback through an output register backed by a one-entry skid buffer.
// Optional macro FPCMP_STATS_EN adds saturating transfer / nv counters.
module fp_cmp_result80 #(
   parameter int unsigned TAGW = 6,
   parameter int unsigned RESW = 64
) (
   input  logic                clk,
   input  logic                rst,
   fp_cmp_result80_if.slave    bus,
   input  logic                clr_flags,
   output logic                flag_nv,
   output logic                flag_inf
`ifdef FPCMP_STATS_EN
   ,
   output logic [31:0]         stat_cmp,
   output logic [31:0]         stat_nv
`endif
);

   typedef struct packed {
      logic [RESW-1:0] res;
      logic [TAGW-1:0] tag;
      logic            nv;
      logic            illegal;
      logic            inf;
   } entry_t;

   entry_t new_e;
   entry_t out_e;
   entry_t skid_e;
   logic   out_valid_r;
   logic   skid_valid;
   logic   in_ready_r;
   logic   in_xfer;
   logic   out_xfer;

   assign in_xfer  = bus.in_valid && in_ready_r;
   assign out_xfer = out_valid_r && bus.out_ready;

   // Decode the predicate and invalid exception for the incoming compare.
   always_comb begin
      new_e     = '0;
      new_e.tag = bus.in_tag;
      new_e.inf = bus.in_inf;
      case (bus.in_op)
         4'd0, 4'd1, 4'd2, 4'd3, 4'd4,
         4'd8, 4'd9, 4'd10, 4'd11, 4'd12: new_e.res[0]    = bus.in_cmp[bus.in_op];
         4'd15:                           new_e.res[15:0] = bus.in_cmp;
         default:                         new_e.illegal   = 1'b1;
      endcase
      // Upstream nan flag is deliberately not used: only unordered (signaling)
      // or an sNaN operand (quiet) raise invalid.
      new_e.nv = !new_e.illegal && (bus.in_sig ? bus.in_cmp[4] : bus.in_snan);
   end

   // Output register with skid buffer; in_ready is registered as ~skid_valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r <= 1'b0;
         skid_valid  <= 1'b0;
         in_ready_r  <= 1'b1;
         out_e       <= '0;
         skid_e      <= '0;
      end else begin
         if (out_xfer || !out_valid_r) begin
            // in_ready is low whenever skid holds data, so in_xfer cannot
            // coincide with a skid refill of the output register.
            if (skid_valid) begin
               out_e       <= skid_e;
               out_valid_r <= 1'b1;
               skid_valid  <= 1'b0;
               in_ready_r  <= 1'b1;
            end else if (in_xfer) begin
               out_e       <= new_e;
               out_valid_r <= 1'b1;
            end else begin
               out_valid_r <= 1'b0;
            end
         end else if (in_xfer) begin
            skid_e     <= new_e;
            skid_valid <= 1'b1;
            in_ready_r <= 1'b0;
         end
      end
   end

   assign bus.in_ready    = in_ready_r;
   assign bus.out_valid   = out_valid_r;
   assign bus.out_res     = out_e.res;
   assign bus.out_tag     = out_e.tag;
   assign bus.out_nv      = out_e.nv;
   assign bus.out_illegal = out_e.illegal;

   // Sticky flags: a set on this cycle's transfer wins over a clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         flag_nv  <= 1'b0;
         flag_inf <= 1'b0;
      end else begin
         flag_nv  <= (out_xfer && out_e.nv)  || (flag_nv  && !clr_flags);
         flag_inf <= (out_xfer && out_e.inf) || (flag_inf && !clr_flags);
      end
   end

`ifdef FPCMP_STATS_EN
   logic [31:0] stat_cmp_r;
   logic [31:0] stat_nv_r;

   // Saturating transfer counters; clear with a coincident increment leaves 1.
   always_ff @(posedge clk) begin
      if (rst) begin
         stat_cmp_r <= '0;
         stat_nv_r  <= '0;
      end else begin
         if (clr_flags)
            stat_cmp_r <= {31'd0, out_xfer};
         else if (out_xfer && stat_cmp_r != '1)
            stat_cmp_r <= stat_cmp_r + 32'd1;

         if (clr_flags)
            stat_nv_r <= {31'd0, out_xfer && out_e.nv};
         else if (out_xfer && out_e.nv && stat_nv_r != '1)
            stat_nv_r <= stat_nv_r + 32'd1;
      end
   end

   assign stat_cmp = stat_cmp_r;
   assign stat_nv  = stat_nv_r;
`endif

endmodule

// File: tb/tb_fp_cmp_result80.sv
// Directed bench for fp_cmp_result80: predicate select, quiet/signaling
// invalid, skid backpressure ordering, flag set/clear collision, mid-stream
// reset and (with FPCMP_STATS_EN) the saturating counters.
module tb_fp_cmp_result80;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr_flags = 1'b0;
   logic flag_nv;
   logic flag_inf;
`ifdef FPCMP_STATS_EN
   logic [31:0] stat_cmp;
   logic [31:0] stat_nv;
`endif

   int checks = 0;
   int errors = 0;

   fp_cmp_result80_if #(.TAGW(6), .RESW(64)) bus ();

   fp_cmp_result80 #(.TAGW(6), .RESW(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .clr_flags (clr_flags),
      .flag_nv   (flag_nv),
      .flag_inf  (flag_inf)
`ifdef FPCMP_STATS_EN
      ,
      .stat_cmp  (stat_cmp),
      .stat_nv   (stat_nv)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   // Called #1 after a rising edge; presents one entry for one cycle.
   task automatic send(input logic [15:0] cmp, input logic snan, input logic inf,
                       input logic [3:0] op, input logic sig, input logic [5:0] tag);
      bus.in_cmp   = cmp;
      bus.in_snan  = snan;
      bus.in_inf   = inf;
      bus.in_op    = op;
      bus.in_sig   = sig;
      bus.in_tag   = tag;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Output monitor: records transfers and checks stability during stalls.
   logic [5:0]  got_tag[$];
   logic [63:0] got_res[$];
   bit          rec_en = 1'b0;
   bit          prev_stall = 1'b0;
   bit          prev_rst = 1'b0;
   logic [63:0] held_res;
   logic [5:0]  held_tag;
   logic        held_nv;
   logic        held_ill;

   always @(negedge clk) begin
      if (prev_stall && !prev_rst && !rst) begin
         check("hold_res", bus.out_res, held_res);
         check("hold_tag", {58'd0, bus.out_tag}, {58'd0, held_tag});
         check("hold_nv",  {63'd0, bus.out_nv}, {63'd0, held_nv});
         check("hold_ill", {63'd0, bus.out_illegal}, {63'd0, held_ill});
      end
      if (rec_en && !rst && bus.out_valid && bus.out_ready) begin
         got_tag.push_back(bus.out_tag);
         got_res.push_back(bus.out_res);
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_rst   = rst;
      held_res   = bus.out_res;
      held_tag   = bus.out_tag;
      held_nv    = bus.out_nv;
      held_ill   = bus.out_illegal;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   logic [3:0]  p_op  [8] = '{4'd0, 4'd1, 4'd2, 4'd9, 4'd10, 4'd15, 4'd6, 4'd14};
   logic [63:0] p_res [8] = '{64'd1, 64'd0, 64'd1, 64'd1, 64'd0, 64'h1A05, 64'd0, 64'd0};
   logic        p_ill [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

   initial begin
      int tag_n;
      int low_cycles;
      bit ok;

      bus.in_valid  = 1'b0;
      bus.in_cmp    = '0;
      bus.in_snan   = 1'b0;
      bus.in_inf    = 1'b0;
      bus.in_op     = '0;
      bus.in_sig    = 1'b0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("rst_in_ready",  {63'd0, bus.in_ready}, 64'd1);
      check("rst_out_res",   bus.out_res, 64'd0);
      check("rst_out_tag",   {58'd0, bus.out_tag}, 64'd0);
      check("rst_flags",     {62'd0, flag_nv, flag_inf}, 64'd0);

      // Predicate select on vector 16'h1A05
      for (int i = 0; i < 8; i++) begin
         send(16'h1A05, 1'b0, 1'b0, p_op[i], 1'b0, 6'(i + 1));
         check("pred_valid", {63'd0, bus.out_valid}, 64'd1);
         check("pred_res",   bus.out_res, p_res[i]);
         check("pred_ill",   {63'd0, bus.out_illegal}, {63'd0, p_ill[i]});
         check("pred_tag",   {58'd0, bus.out_tag}, 64'(i + 1));
      end
      tick();
      check("pred_drained", {63'd0, bus.out_valid}, 64'd0);

      // Quiet compare with unordered: no invalid
      send(16'h0010, 1'b0, 1'b0, 4'd4, 1'b0, 6'd20);
      check("quiet_res", bus.out_res, 64'd1);
      check("quiet_nv",  {63'd0, bus.out_nv}, 64'd0);
      tick();
      check("quiet_flag", {63'd0, flag_nv}, 64'd0);
      // Signaling compare with unordered: invalid
      send(16'h0010, 1'b0, 1'b0, 4'd4, 1'b1, 6'd21);
      check("sig_nv", {63'd0, bus.out_nv}, 64'd1);
      check("sig_flag_before", {63'd0, flag_nv}, 64'd0);
      tick();
      check("sig_flag", {63'd0, flag_nv}, 64'd1);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("clr_flag", {63'd0, flag_nv}, 64'd0);
      // Quiet compare with sNaN: invalid
      send(16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 6'd22);
      check("snan_nv",  {63'd0, bus.out_nv}, 64'd1);
      check("snan_res", bus.out_res, 64'd0);
      // Reserved op never raises invalid
      send(16'h0010, 1'b1, 1'b0, 4'd13, 1'b1, 6'd23);
      check("rsv_nv",  {63'd0, bus.out_nv}, 64'd0);
      check("rsv_ill", {63'd0, bus.out_illegal}, 64'd1);
      // Infinity operand sets flag_inf on transfer
      check("inf_flag_before", {63'd0, flag_inf}, 64'd0);
      send(16'h0000, 1'b0, 1'b1, 4'd2, 1'b0, 6'd24);
      tick();
      check("inf_flag", {63'd0, flag_inf}, 64'd1);

      // Set/clear collision
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("coll_pre", {62'd0, flag_nv, flag_inf}, 64'd0);
      send(16'h0010, 1'b0, 1'b0, 4'd0, 1'b1, 6'd25);
      check("coll_nv", {63'd0, bus.out_nv}, 64'd1);
      clr_flags = 1'b1;
      tick();
      check("coll_set_wins", {63'd0, flag_nv}, 64'd1);
      tick();
      check("coll_clear", {63'd0, flag_nv}, 64'd0);
      clr_flags = 1'b0;

      // Backpressure: tags 1..6, out_ready low for stream cycles 2-4
      got_tag.delete();
      got_res.delete();
      rec_en = 1'b1;
      tag_n = 1;
      low_cycles = 0;
      for (int cyc = 0; cyc < 40 && tag_n <= 6; cyc++) begin
         bus.out_ready = !(cyc >= 2 && cyc <= 4);
         bus.in_cmp    = 16'(tag_n);
         bus.in_op     = 4'd15;
         bus.in_sig    = 1'b0;
         bus.in_snan   = 1'b0;
         bus.in_inf    = 1'b0;
         bus.in_tag    = 6'(tag_n);
         bus.in_valid  = 1'b1;
         ok = bus.in_ready;
         if (!ok) low_cycles++;
         tick();
         if (ok) tag_n++;
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) tick();
      rec_en = 1'b0;
      check("bp_in_ready_low", 64'(low_cycles), 64'd3);
      check("bp_count", 64'(got_tag.size()), 64'd6);
      for (int i = 0; i < 6; i++) begin
         if (i < got_tag.size()) begin
            check("bp_tag", {58'd0, got_tag[i]}, 64'(i + 1));
            check("bp_res", got_res[i], 64'(i + 1));
         end
      end

      // Reset mid-stream with two entries held
      send(16'h0010, 1'b0, 1'b1, 4'd4, 1'b1, 6'd30);
      tick();
      check("mr_flags_set", {62'd0, flag_nv, flag_inf}, 64'd3);
      bus.out_ready = 1'b0;
      send(16'h0001, 1'b0, 1'b0, 4'd0, 1'b0, 6'd9);
      send(16'h0001, 1'b0, 1'b0, 4'd0, 1'b0, 6'd10);
      check("mr_full", {62'd0, bus.out_valid, bus.in_ready}, 64'd2);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_out_valid", {63'd0, bus.out_valid}, 64'd0);
      check("mr_in_ready",  {63'd0, bus.in_ready}, 64'd1);
      check("mr_flags",     {62'd0, flag_nv, flag_inf}, 64'd0);
      check("mr_out_tag",   {58'd0, bus.out_tag}, 64'd0);
      got_tag.delete();
      got_res.delete();
      rec_en = 1'b1;
      bus.out_ready = 1'b1;
      repeat (5) tick();
      check("mr_no_stale", 64'(got_tag.size()), 64'd0);
      send(16'h0001, 1'b0, 1'b0, 4'd0, 1'b0, 6'd11);
      tick();
      rec_en = 1'b0;
      check("mr_after_count", 64'(got_tag.size()), 64'd1);
      if (got_tag.size() > 0) check("mr_after_tag", {58'd0, got_tag[0]}, 64'd11);

`ifdef FPCMP_STATS_EN
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("st_clear", {stat_cmp, stat_nv}, 64'd0);
      send(16'h0010, 1'b0, 1'b0, 4'd4, 1'b1, 6'd40);
      send(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 6'd41);
      send(16'h0000, 1'b1, 1'b0, 4'd0, 1'b0, 6'd42);
      tick();
      check("st_cmp", {32'd0, stat_cmp}, 64'd3);
      check("st_nv",  {32'd0, stat_nv}, 64'd2);
      force dut.stat_cmp_r = 32'hFFFF_FFFF;
      tick();
      release dut.stat_cmp_r;
      send(16'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 6'd43);
      tick();
      check("st_sat", {32'd0, stat_cmp}, 64'hFFFF_FFFF);
      send(16'h0010, 1'b0, 1'b0, 4'd4, 1'b1, 6'd44);
      clr_flags = 1'b1;
      tick();
      clr_flags = 1'b0;
      check("st_clr_inc_cmp", {32'd0, stat_cmp}, 64'd1);
      check("st_clr_inc_nv",  {32'd0, stat_nv}, 64'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fp_cmp_result80.md
Name: fp_cmp_result80

Overview:
- Consumer stage directly downstream of the 80-bit FP compare unit.
- Takes the 16-bit compare vector and the nan/snan/inf flags, selects the predicate requested by the instruction, and computes the IEEE invalid exception (quiet vs signaling compare).
- Accumulates sticky status flags and delivers results to writeback through a valid/ready pipeline register with a skid buffer.

Parameters:
- TAGW, 6, width of the instruction tag carried alongside each compare.
- RESW, 64, width of the result bus; a predicate is zero-extended, the full vector is zero-extended from bit 15.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  upstream has a compare result
- in_ready  out  1  stage can accept
- in_cmp  in  16  compare vector: [0]eq [1]lt [2]le [3]magnitude-lt [4]unordered [8]ne [9]ge [10]gt [11]~mag-lt [12]ordered
- in_snan  in  1  either operand is a signaling NaN
- in_inf  in  1  either operand infinite
- in_op  in  4  predicate select
- in_sig  in  1  1 = signaling compare, 0 = quiet
- in_tag  in  TAGW  instruction tag
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts
- out_res  out  RESW  result
- out_tag  out  TAGW  tag
- out_nv  out  1  this result raised invalid
- out_illegal  out  1  reserved op
- clr_flags  in  1  clear sticky flags
- flag_nv  out  1  sticky invalid
- flag_inf  out  1  sticky infinity-operand seen

Behaviour:
- Op decode:
  - op 0..4 selects in_cmp[op].
  - op 8..12 selects in_cmp[op].
  - op 15 returns in_cmp[15:0].
  - op 5,6,7,13,14 are reserved: result 0, out_illegal=1, out_nv=0.
- Invalid rule: nv = in_sig ? in_cmp[4] : in_snan. This ignores the upstream nan flag's inf&inf term. Reserved ops never raise nv.
- Handshake:
  - Input transfer on in_valid&&in_ready; output transfer on out_valid&&out_ready.
  - in_ready is a register: in_ready = ~skid_valid.
  - Accepted data goes to the output register if it is empty or being drained this cycle, else to the skid register.
  - On output drain with skid_valid, skid moves to the output register the same cycle and in_ready rises next cycle.
- Latency: 1 cycle from input transfer to out_valid, with no stall.
- Throughput: 1 per cycle while out_ready=1.
- Ordering: results are strictly in order; no loss or duplication under any out_ready pattern.
- Output stability: while out_valid && !out_ready, all out_* are held stable.
- Sticky flags:
  - flag_nv is set on an output transfer with out_nv=1.
  - flag_inf is set on an output transfer whose in_inf was 1. The inf bit is carried internally per entry.
  - clr_flags clears both flags. If a set and a clear occur in the same cycle, set wins.
- Reset (rst=1 at clk edge):
  - out_valid=0, skid_valid=0, in_ready=1 (the first cycle after reset already accepts).
  - out_res=0, out_tag=0, out_nv=0, out_illegal=0, flag_nv=0, flag_inf=0.
  - Reset mid-operation discards all in-flight entries with no output transfer.
- Simultaneous input and output transfer with skid empty: the output register is reloaded with the new entry; out_valid stays 1.

Optional Feature:
- Macro: FPCMP_STATS_EN.
- When defined, adds two outputs:
  - stat_cmp[31:0]: counts output transfers.
  - stat_nv[31:0]: counts output transfers with out_nv=1.
- Both counters saturate at 32'hFFFFFFFF, reset to 0, and clear on clr_flags. If increment and clear occur in the same cycle, the counter ends at 1.
- When undefined, the ports and counters are absent and the rest of the behaviour is identical.

Test Plan:
- Predicate select: in_cmp=16'h1A05, op=0 → out_res=1; op=1 → 0; op=15 → 64'h1A05; op=6 → out_res=0, out_illegal=1.
- Quiet vs signaling: in_cmp[4]=1, in_snan=0, in_sig=0 → out_nv=0, flag_nv stays 0. Same with in_sig=1 → out_nv=1, flag_nv=1 after the transfer. in_snan=1, in_sig=0 → out_nv=1.
- Backpressure: stream tags 1..6 back-to-back, out_ready=0 for cycles 2-4 → in_ready drops after the 2nd buffered entry; outputs appear as 1..6 in order with no drops; out_* stable during the stall.
- Flag set/clear collision: clr_flags=1 in the same cycle as an nv transfer → flag_nv=1. clr_flags alone the next cycle → flag_nv=0.
- Reset mid-stream: two entries held (out_ready=0), assert rst one cycle → out_valid=0, in_ready=1, flags 0, and no stale tag appears later.
- With FPCMP_STATS_EN: 3 transfers, 2 with nv → stat_cmp=3, stat_nv=2. Preload stat_cmp=32'hFFFFFFFF via force, then 1 transfer → stays 32'hFFFFFFFF.
